// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a combinational ROM and
// hands fetched words to decode through a one-entry valid/ready output slot.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        valid_reg, valid_next;
    logic [31:0] data_reg, data_next;
    logic [31:0] slot_pc_reg, slot_pc_next;
    logic [31:0] fault_pc_reg, fault_pc_next;

    logic slot_free;
    logic transfer;
    logic redirect_misaligned;

    assign slot_free           = !valid_reg || inst_ready;
    assign transfer            = valid_reg && inst_ready;
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= RESET_PC;
            valid_reg    <= 1'b0;
            data_reg     <= 32'h0;
            slot_pc_reg  <= 32'h0;
            fault_pc_reg <= 32'h0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            valid_reg    <= valid_next;
            data_reg     <= data_next;
            slot_pc_reg  <= slot_pc_next;
            fault_pc_reg <= fault_pc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        valid_next    = valid_reg;
        data_next     = data_reg;
        slot_pc_next  = slot_pc_reg;
        fault_pc_next = fault_pc_reg;

        case (state_reg)
            ST_IDLE: begin
                if (transfer) begin
                    valid_next = 1'b0;
                end
                // start wins over a simultaneous redirect; the PC stays at RESET_PC
                if (start) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (redirect_valid && redirect_misaligned) begin
                    fault_pc_next = redirect_pc;
                    valid_next    = 1'b0;
                    state_next    = ST_FAULT;
                end else if (redirect_valid) begin
                    // The redirect cycle is the bubble: flush, no fetch.
                    pc_next    = redirect_pc;
                    valid_next = 1'b0;
                end else if (slot_free && HALT_ON_ZERO && (imem_rdata == 32'h0)) begin
                    valid_next = 1'b0;
                    state_next = ST_HALT;
                end else if (slot_free) begin
                    data_next    = imem_rdata;
                    slot_pc_next = pc_reg;
                    valid_next   = 1'b1;
                    pc_next      = pc_reg + 32'd4;
                end
            end

            ST_HALT: begin
                if (transfer) begin
                    valid_next = 1'b0;
                end
                if (redirect_valid && redirect_misaligned) begin
                    fault_pc_next = redirect_pc;
                    state_next    = ST_FAULT;
                end else if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = ST_RUN;
                end
            end

            default: begin
                if (transfer) begin
                    valid_next = 1'b0;
                end
            end
        endcase
    end

    assign imem_addr  = pc_reg;
    assign inst_valid = valid_reg;
    assign inst_data  = data_reg;
    assign inst_pc    = slot_pc_reg;
    assign halted     = (state_reg == ST_HALT);
    assign fault      = (state_reg == ST_FAULT);
    assign fault_pc   = fault_pc_reg;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a small combinational ROM model.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;

    int checks;
    int errors;

    logic [31:0] rom [0:15];

    imem_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .HALT_ON_ZERO(1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .halted        (halted),
        .fault         (fault),
        .fault_pc      (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rom[0]  = 32'h0ff02083; rom[1]  = 32'h00f0f193;
        rom[2]  = 32'h0f00f213; rom[3]  = 32'h00208093;
        rom[4]  = 32'h00310113; rom[5]  = 32'h00418193;
        rom[6]  = 32'h00520213; rom[7]  = 32'h00628293;
        rom[8]  = 32'h00730313; rom[9]  = 32'h00100113;
        rom[10] = 32'h00432433; rom[11] = 32'h00838393;
        rom[12] = 32'h00940413; rom[13] = 32'h00a48493;
        rom[14] = 32'h00b50513; rom[15] = 32'h0e502fa3;
    end

    // Unmapped addresses read as zero, except the top word used for the wrap test.
    always_comb begin
        if (imem_addr < 32'h40)
            imem_rdata = rom[imem_addr[5:2]];
        else if (imem_addr == 32'hFFFF_FFFC)
            imem_rdata = 32'h00000073;
        else
            imem_rdata = 32'h0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Pulse start and wait the two edges until the first word is in the slot.
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b1;
        tick();
        checks++;
        if ({inst_valid, halted, fault} !== 3'b000 || inst_data !== 32'h0 || inst_pc !== 32'h0
            || fault_pc !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b halted=%b fault=%b data=%h pc=%h fpc=%h addr=%h, required all zero",
                     inst_valid, halted, fault, inst_data, inst_pc, fault_pc, imem_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (inst_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL idle_no_fetch: valid=%b addr=%h, required valid=0 addr=0", inst_valid, imem_addr);
        end
        $display("test_reset done");
    endtask

    task automatic test_start_stream();
        logic [31:0] exp_pc [0:2];
        logic [31:0] exp_d  [0:2];
        exp_pc[0] = 32'h0; exp_d[0] = 32'h0ff02083;
        exp_pc[1] = 32'h4; exp_d[1] = 32'h00f0f193;
        exp_pc[2] = 32'h8; exp_d[2] = 32'h0f00f213;
        inst_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_latency: valid=%b one edge after start, required 0", inst_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc[i] || inst_data !== exp_d[i]) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b pc=%h data=%h, required 1 %h %h",
                         i, inst_valid, inst_pc, inst_data, exp_pc[i], exp_d[i]);
            end else begin
                $display("stream word %0d: pc=%h data=%h", i, inst_pc, inst_data);
            end
        end
    endtask

    task automatic test_back_pressure();
        apply_reset();
        start_run();
        tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== 32'h00f0f193 || imem_addr !== 32'h8) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: valid=%b pc=%h data=%h addr=%h, required 1 00000004 00f0f193 00000008",
                         i, inst_valid, inst_pc, inst_data, imem_addr);
            end
        end
        inst_ready = 1'b1;
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_data !== 32'h0f00f213) begin
            errors++;
            $display("FAIL backpressure_release: valid=%b pc=%h data=%h, required 1 00000008 0f00f213",
                     inst_valid, inst_pc, inst_data);
        end
        $display("test_back_pressure done");
    endtask

    task automatic test_redirect();
        tick();
        tick();
        checks++;
        if (inst_pc !== 32'h10 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_setup: pc=%h valid=%b, required 00000010 1", inst_pc, inst_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h24;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_addr !== 32'h24) begin
            errors++;
            $display("FAIL redirect_flush: valid=%b addr=%h, required 0 00000024", inst_valid, imem_addr);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h24 || inst_data !== 32'h00100113) begin
            errors++;
            $display("FAIL redirect_target: valid=%b pc=%h data=%h, required 1 00000024 00100113",
                     inst_valid, inst_pc, inst_data);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h28 || inst_data !== 32'h00432433) begin
            errors++;
            $display("FAIL redirect_next: valid=%b pc=%h data=%h, required 1 00000028 00432433",
                     inst_valid, inst_pc, inst_data);
        end
        $display("test_redirect done");
    endtask

    task automatic test_halt();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h3C || inst_data !== 32'h0e502fa3) begin
            errors++;
            $display("FAIL halt_last_word: valid=%b pc=%h data=%h, required 1 0000003c 0e502fa3",
                     inst_valid, inst_pc, inst_data);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL halt_on_zero: halted=%b valid=%b addr=%h, required 1 0 00000040",
                     halted, inst_valid, imem_addr);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_stays: halted=%b valid=%b, required 1 0", halted, inst_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (halted !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL halt_resume: halted=%b valid=%b addr=%h, required 0 0 00000000",
                     halted, inst_valid, imem_addr);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0ff02083) begin
            errors++;
            $display("FAIL halt_resume_word: valid=%b pc=%h data=%h, required 1 00000000 0ff02083",
                     inst_valid, inst_pc, inst_data);
        end
        $display("test_halt done");
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1;
        redirect_pc = 32'h1E;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_pc !== 32'h1E || inst_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL fault_enter: fault=%b fpc=%h valid=%b halted=%b, required 1 0000001e 0 0",
                     fault, fault_pc, inst_valid, halted);
        end
        start = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        tick();
        tick();
        start = 1'b0;
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (fault !== 1'b1 || fault_pc !== 32'h1E || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky: fault=%b fpc=%h valid=%b, required 1 0000001e 0",
                     fault, fault_pc, inst_valid);
        end
        apply_reset();
        checks++;
        if (fault !== 1'b0 || fault_pc !== 32'h0) begin
            errors++;
            $display("FAIL fault_cleared: fault=%b fpc=%h, required 0 00000000", fault, fault_pc);
        end
        $display("test_fault done");
    endtask

    task automatic test_async_reset();
        start_run();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({inst_valid, halted, fault} !== 3'b000 || inst_data !== 32'h0 || inst_pc !== 32'h0
            || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%b halted=%b fault=%b data=%h pc=%h addr=%h, required all zero",
                     inst_valid, halted, fault, inst_data, inst_pc, imem_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start_run();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0ff02083) begin
            errors++;
            $display("FAIL async_restart: valid=%b pc=%h data=%h, required 1 00000000 0ff02083",
                     inst_valid, inst_pc, inst_data);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== 32'h00000073 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: valid=%b pc=%h data=%h addr=%h, required 1 fffffffc 00000073 00000000",
                     inst_valid, inst_pc, inst_data, imem_addr);
        end
        $display("test_wrap done");
    endtask

    task automatic test_idle_start_and_redirect();
        apply_reset();
        start = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        tick();
        start = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL idle_start_wins: addr=%h, required 00000000", imem_addr);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL idle_start_word: valid=%b pc=%h, required 1 00000000", inst_valid, inst_pc);
        end
        $display("test_idle_start_and_redirect done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_start_stream();
        test_back_pressure();
        test_redirect();
        test_halt();
        test_fault();
        test_async_reset();
        test_wrap();
        test_idle_start_and_redirect();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
